// File: rtl/lsu_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The LSU takes the slave side; the core/memory environment takes the master side.
interface lsu_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_fault;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: lane steering, byte enables, load extension and
// splitting of misaligned accesses into two aligned word accesses.
module lsu_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   lo_q;
    logic [DATA_WIDTH-1:0]   hi_q;
    logic                    split_q;
    logic                    fault_q;

    logic                    accept;
    logic                    illegal;
    logic                    split_in;
    logic                    fault_in;
    logic [1:0]              o_in;
    logic [1:0]              o;
    logic [3:0]              be_base;
    logic [7:0]              be8;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [2*DATA_WIDTH-1:0] wd64;
    logic [ADDR_WIDTH-3:0]   word_nx;
    logic [DATA_WIDTH-1:0]   ext;
    logic [DATA_WIDTH-1:0]   ld;

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);

    // Request classification on the incoming (not yet latched) request
    always_comb begin
        o_in     = bus.req_addr[1:0];
        illegal  = (bus.req_funct3[1:0] == 2'b11)
                || (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
        split_in = ((bus.req_funct3[1:0] == 2'b01) && (o_in == 2'd3))
                || ((bus.req_funct3[1:0] == 2'b10) && (o_in != 2'd0));
        fault_in = illegal || (split_in && !ALLOW_MISALIGNED);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = fault_in ? RESP : ACC1;
            ACC1:    state_nx = split_q ? ACC2 : RESP;
            ACC2:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane steering: bits beyond lane 3 spill into the second access
    always_comb begin
        o = addr_q[1:0];
        unique case (1'b1)
            f3_q[1:0] == 2'b00: be_base = 4'b0001;
            f3_q[1:0] == 2'b01: be_base = 4'b0011;
            default:            be_base = 4'b1111;
        endcase
        unique case (1'b1)
            f3_q[1:0] == 2'b00: wmask = {24'b0, wdata_q[7:0]};
            f3_q[1:0] == 2'b01: wmask = {16'b0, wdata_q[15:0]};
            default:            wmask = wdata_q;
        endcase
        be8     = {4'b0, be_base} << o;
        wd64    = {{DATA_WIDTH{1'b0}}, wmask} << {o, 3'b000};
        word_nx = addr_q[ADDR_WIDTH-1:2]
                + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            ACC1: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_be    = be8[3:0];
                bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                bus.mem_wdata = wd64[DATA_WIDTH-1:0];
            end
            ACC2: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_be    = be8[7:4];
                bus.mem_addr  = {word_nx, 2'b00};
                bus.mem_wdata = wd64[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        ext = DATA_WIDTH'({hi_q, lo_q} >> {o, 3'b000});
        unique case (1'b1)
            f3_q == 3'b000: ld = {{24{ext[7]}}, ext[7:0]};
            f3_q == 3'b001: ld = {{16{ext[15]}}, ext[15:0]};
            f3_q == 3'b100: ld = {24'b0, ext[7:0]};
            f3_q == 3'b101: ld = {16'b0, ext[15:0]};
            default:        ld = ext;
        endcase
        bus.resp_valid = (state == RESP);
        bus.resp_fault = (state == RESP) && fault_q;
        bus.resp_rdata = ((state == RESP) && !we_q && !fault_q) ? ld : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                split_q <= split_in;
                fault_q <= fault_in;
                lo_q    <= '0;
                hi_q    <= '0;
            end
            if (state == ACC1 && !we_q) lo_q <= bus.mem_rdata;
            if (state == ACC2 && !we_q) hi_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table against a byte-enabled memory
// model, plus reset, no-misalign and reset-during-split sequences.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lsu_if #(.DW(32), .AW(32)) bus0 ();
    lsu_if #(.DW(32), .AW(32)) bus1 ();

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    logic [31:0] mem [256];
    assign bus0.mem_rdata = mem[bus0.mem_addr[9:2]];
    assign bus1.mem_rdata = 32'h1234_5678;

    always @(posedge clk) begin
        if (bus0.mem_en && bus0.mem_we)
            for (int b = 0; b < 4; b++)
                if (bus0.mem_be[b])
                    mem[bus0.mem_addr[9:2]][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          nacc;
        logic [31:0] a1;
        logic [3:0]  b1;
        logic [31:0] w1;
        logic [31:0] a2;
        logic [3:0]  b2;
        logic [31:0] w2;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(
        input logic we, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata,
        input int lat, input int nacc,
        input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
        input logic [31:0] a2, input logic [3:0] b2, input logic [31:0] w2,
        input logic [31:0] rdata, input logic fault);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.nacc = nacc;
        v.a1 = a1; v.b1 = b1; v.w1 = w1;
        v.a2 = a2; v.b2 = b2; v.w2 = w2;
        v.rdata = rdata; v.fault = fault;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0;
        bus0.req_funct3 = 3'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0;
        bus1.req_funct3 = 3'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    endtask

    task automatic run0(input vec_t v, input int idx);
        int          lat;
        int          n;
        logic [31:0] ga [2];
        logic [3:0]  gb [2];
        logic [31:0] gw [2];
        logic        gwe [2];
        logic [31:0] rd;
        logic        flt;
        lat = 0; n = 0; rd = '0; flt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ga[k] = '0; gb[k] = '0; gw[k] = '0; gwe[k] = 1'b0;
        end
        @(negedge clk);
        chk("ready_idle", idx, {31'b0, bus0.req_ready}, 32'd1);
        bus0.req_we = v.we; bus0.req_funct3 = v.f3;
        bus0.req_addr = v.addr; bus0.req_wdata = v.wdata;
        bus0.req_valid = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (bus0.mem_en) begin
                if (n < 2) begin
                    ga[n] = bus0.mem_addr; gb[n] = bus0.mem_be;
                    gw[n] = bus0.mem_wdata; gwe[n] = bus0.mem_we;
                end
                n++;
            end
            if (bus0.resp_valid) begin
                lat = c; rd = bus0.resp_rdata; flt = bus0.resp_fault;
                chk("ready_resp", idx, {31'b0, bus0.req_ready}, 32'd0);
            end
        end
        chk("latency", idx, lat, v.lat);
        chk("accesses", idx, n, v.nacc);
        chk("rdata", idx, rd, v.rdata);
        chk("fault", idx, {31'b0, flt}, {31'b0, v.fault});
        if (v.nacc >= 1) begin
            chk("a1", idx, ga[0], v.a1);
            chk("be1", idx, {28'b0, gb[0]}, {28'b0, v.b1});
            chk("wd1", idx, gw[0], v.w1);
            chk("we1", idx, {31'b0, gwe[0]}, {31'b0, v.we});
        end
        if (v.nacc == 2) begin
            chk("a2", idx, ga[1], v.a2);
            chk("be2", idx, {28'b0, gb[1]}, {28'b0, v.b2});
            chk("wd2", idx, gw[1], v.w2);
            chk("we2", idx, {31'b0, gwe[1]}, {31'b0, v.we});
        end
    endtask

    initial begin
        int lat;
        int n;
        int seen;
        logic [31:0] rd;
        logic flt;

        vecs[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 1,
                      32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 3'b010, 32'h100, 32'h80FF1234, 2, 1,
                      32'h100, 4'b1111, 32'h80FF1234, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 3'b000, 32'h103, 0, 2, 1,
                      32'h100, 4'b1000, 0, 0, 0, 0, 32'hFFFFFF80, 0);
        vecs[3]  = mk(0, 3'b100, 32'h103, 0, 2, 1,
                      32'h100, 4'b1000, 0, 0, 0, 0, 32'h00000080, 0);
        vecs[4]  = mk(0, 3'b001, 32'h102, 0, 2, 1,
                      32'h100, 4'b1100, 0, 0, 0, 0, 32'hFFFF80FF, 0);
        vecs[5]  = mk(0, 3'b101, 32'h102, 0, 2, 1,
                      32'h100, 4'b1100, 0, 0, 0, 0, 32'h000080FF, 0);
        vecs[6]  = mk(0, 3'b010, 32'h100, 0, 2, 1,
                      32'h100, 4'b1111, 0, 0, 0, 0, 32'h80FF1234, 0);
        vecs[7]  = mk(1, 3'b010, 32'h100, 32'h44332211, 2, 1,
                      32'h100, 4'b1111, 32'h44332211, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 3'b010, 32'h104, 32'h88776655, 2, 1,
                      32'h104, 4'b1111, 32'h88776655, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 3'b010, 32'h102, 0, 3, 2,
                      32'h100, 4'b1100, 0, 32'h104, 4'b0011, 0,
                      32'h66554433, 0);
        vecs[10] = mk(1, 3'b001, 32'h107, 32'h0000ABCD, 3, 2,
                      32'h104, 4'b1000, 32'hCD000000,
                      32'h108, 4'b0001, 32'h000000AB, 0, 0);
        vecs[11] = mk(0, 3'b001, 32'h107, 0, 3, 2,
                      32'h104, 4'b1000, 0, 32'h108, 4'b0001, 0,
                      32'hFFFFABCD, 0);
        vecs[12] = mk(1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 3, 2,
                      32'hFFFFFFFC, 4'b1100, 32'h33440000,
                      32'h00000000, 4'b0011, 32'h00001122, 0, 0);
        vecs[13] = mk(0, 3'b011, 32'h100, 0, 1, 0,
                      0, 0, 0, 0, 0, 0, 0, 1);
        vecs[14] = mk(1, 3'b100, 32'h100, 32'h55, 1, 0,
                      0, 0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(1, 3'b000, 32'h101, 32'h777777A5, 2, 1,
                      32'h100, 4'b0010, 32'h0000A500, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 3'b000, 32'h101, 0, 2, 1,
                      32'h100, 4'b0010, 0, 0, 0, 0, 32'hFFFFFFA5, 0);
        vecs[17] = mk(0, 3'b010, 32'h101, 0, 3, 2,
                      32'h100, 4'b1110, 0, 32'h104, 4'b0001, 0,
                      32'h554433A5, 0);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 0, {31'b0, bus0.req_ready}, 32'd1);
        chk("rst_valid", 0, {31'b0, bus0.resp_valid}, 32'd0);
        chk("rst_fault", 0, {31'b0, bus0.resp_fault}, 32'd0);
        chk("rst_rdata", 0, bus0.resp_rdata, 32'd0);
        chk("rst_en", 0, {31'b0, bus0.mem_en}, 32'd0);
        chk("rst_be", 0, {28'b0, bus0.mem_be}, 32'd0);
        chk("rst_addr", 0, bus0.mem_addr, 32'd0);
        chk("rst_wdata", 0, bus0.mem_wdata, 32'd0);
        chk("rst_ready1", 0, {31'b0, bus1.req_ready}, 32'd1);

        for (int i = 0; i < 18; i++) run0(vecs[i], i);

        // Misaligned word on the no-split instance faults without access
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus1.req_we = 1'b0; bus1.req_funct3 = 3'b010;
            bus1.req_addr = (t == 0) ? 32'h101 : 32'h100;
            bus1.req_valid = 1'b1;
            @(posedge clk);
            #1 idle_inputs();
            lat = 0; n = 0; rd = '0; flt = 1'b0;
            for (int c = 1; c <= 5 && lat == 0; c++) begin
                @(negedge clk);
                if (bus1.mem_en) n++;
                if (bus1.resp_valid) begin
                    lat = c; rd = bus1.resp_rdata; flt = bus1.resp_fault;
                end
            end
            chk("nm_latency", t, lat, (t == 0) ? 1 : 2);
            chk("nm_access", t, n, (t == 0) ? 0 : 1);
            chk("nm_fault", t, {31'b0, flt}, (t == 0) ? 32'd1 : 32'd0);
            chk("nm_rdata", t, rd, (t == 0) ? 32'd0 : 32'h12345678);
        end

        // Reset asserted while the second half of a split load is in flight
        @(negedge clk);
        bus0.req_we = 1'b0; bus0.req_funct3 = 3'b010;
        bus0.req_addr = 32'h102; bus0.req_valid = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        chk("ra_acc1", 0, bus0.mem_addr, 32'h100);
        @(negedge clk);
        chk("ra_acc2", 0, bus0.mem_addr, 32'h104);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ra_ready", 0, {31'b0, bus0.req_ready}, 32'd1);
        chk("ra_en", 0, {31'b0, bus0.mem_en}, 32'd0);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus0.resp_valid) seen++;
            @(negedge clk);
        end
        chk("ra_noresp", 0, seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit directly upstream of the data memory.
- Accepts one load/store request at a time from the core's execute stage and drives the word-addressed, byte-enabled data memory port.
- Performs byte-lane steering, byte enables and sign/zero extension.
- Splits misaligned halfword/word accesses into two aligned word accesses and holds the core with a ready/valid handshake until the response is returned.

Parameters:
DATA_WIDTH, 32, data path width (only 32 supported)
ADDR_WIDTH, 32, byte address width
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = misaligned access faults with no memory access

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  LSU can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3: load 000 lb/001 lh/010 lw/100 lbu/101 lhu; store 000 sb/001 sh/010 sw
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
resp_fault  out  1  valid with resp_valid: illegal funct3, or misaligned when ALLOW_MISALIGNED=0
mem_en  out  1  memory access this cycle
mem_we  out  1  write strobe
mem_be  out  4  byte enables, bit i = byte lane i
mem_addr  out  ADDR_WIDTH  word-aligned address, [1:0] = 00
mem_wdata  out  DATA_WIDTH  lane-steered write data
mem_rdata  in  DATA_WIDTH  combinational read data for the mem_addr driven in the same cycle

Behaviour:
- **States:** IDLE, ACC1, ACC2, RESP.
- **Reset (rst_n=0 at an edge):**
  - Next state IDLE; all latched request registers cleared.
  - resp_valid = resp_fault = 0, resp_rdata = 0.
  - req_ready = 1 from the cycle after reset.
  - A reset during ACC2 abandons the request: no resp_valid is produced. A split store may leave its first word written; this is acceptable.
- **mem_* outputs:**
  - Combinational decode of state plus latched registers.
  - In IDLE and RESP: mem_en = mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- **IDLE:**
  - On req_valid && req_ready, latch we/funct3/addr/wdata.
  - Classify: o = addr[1:0]; split = (sh && o == 3) || (sw && o != 0) || the same conditions for lh/lhu/lw.
  - If the request is illegal, or split with ALLOW_MISALIGNED = 0: go to RESP with fault = 1, no memory access.
  - Otherwise go to ACC1.
- **ACC1:**
  - mem_en = 1, mem_we = we, mem_addr = {addr[31:2], 00}.
  - mem_be: sb = 0001 << o; sh = (0011 << o) masked to 4 bits; sw = (1111 << o) masked to 4 bits.
  - mem_wdata = replicated/steered store data shifted left by 8*o.
  - Loads capture mem_rdata into lo_word at the edge.
  - Next state is ACC2 if split, else RESP.
- **ACC2 (split only):**
  - mem_addr = {addr[31:2] + 1, 00}, wrapping modulo 2^ADDR_WIDTH (0xFFFFFFFC → 0x00000000).
  - mem_be = 1111 >> (4 − o) for sw; 0001 for sh with o = 3.
  - mem_wdata = wdata >> 8*(4 − o).
  - Loads capture hi_word.
  - Next state RESP.
- **Load assembly:**
  - ext = ({hi_word, lo_word} >> 8*o)[31:0]; hi_word = 0 when not split.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- **RESP:**
  - resp_valid = 1 for exactly one cycle, with resp_rdata/resp_fault registered.
  - Next state IDLE; req_ready = 0 in this cycle.
- **Latency from accept edge to resp_valid cycle:**
  - Aligned: 2 cycles (ACC1, RESP).
  - Split: 3 cycles.
  - Fault: 1 cycle.
- **Other rules:**
  - req_valid while req_ready = 0 is ignored; the core holds it.
  - Store resp_rdata = 0.
  - Store funct3 values other than 000/001/010 are illegal.
  - Load funct3 011/110/111 are illegal.

Test Plan:
1. Hold rst_n=0 for 2 cycles, then release -> req_ready=1; resp_valid=0, mem_en=0, mem_be=0, all data outputs 0.
2. sw addr 0x100, data 0xDEADBEEF -> one ACC1 cycle with mem_we=1, be=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept, resp_fault=0, resp_rdata=0.
3. mem[0x100]=0x80FF1234: lb 0x103 -> be=1000, resp_rdata=0xFFFFFF80; lbu 0x103 -> 0x00000080; lh 0x102 -> 0xFFFF80FF.
4. mem[0x100]=0x44332211, mem[0x104]=0x88776655: lw 0x102 -> ACC1 reads 0x100, ACC2 reads 0x104; resp_rdata=0x66554433 3 cycles after accept.
5. sh 0x0000ABCD at 0x107 -> ACC1: addr 0x104, be=1000, wdata=0xCD000000. ACC2: addr 0x108, be=0001, wdata=0x000000AB. Also sw at 0xFFFFFFFE -> second access at 0x00000000, be=0011.
6. Load funct3=011 -> mem_en stays 0, resp_fault=1, resp_rdata=0 after 1 cycle. ALLOW_MISALIGNED=0, lw 0x101 -> resp_fault=1, no access. rst_n=0 during ACC2 -> IDLE next cycle, no resp_valid.
